// File: rtl/pulse_stretch.sv
// Pulse stretcher: each din request becomes a HOLD_CYC-wide high on dout,
// separated by at least GAP_CYC low cycles, with excess requests queued.
module pulse_stretch #(
    parameter int HOLD_CYC = 4,
    parameter int GAP_CYC  = 2,
    parameter int PEND_MAX = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic       dout,
    output logic       busy,
    output logic [7:0] pending,
    output logic       overflow
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HIGH = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    // Counter holds cycles remaining after the current one in this state.
    localparam logic [15:0] HOLD_LD = 16'(HOLD_CYC - 1);
    localparam logic [15:0] GAP_LD  = 16'(GAP_CYC - 1);
    localparam logic [7:0]  PMAX    = 8'(PEND_MAX);

    logic [1:0]  state, state_nx;
    logic [15:0] cnt, cnt_nx;
    logic [7:0]  pend_nx;
    logic        ovf_nx;
    logic        start;
    logic        want;

    assign want = din || (pending != 8'd0);

    always_comb begin
        start    = 1'b0;
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (want) begin
                    start    = 1'b1;
                    state_nx = HIGH;
                    cnt_nx   = HOLD_LD;
                end
            end
            HIGH: begin
                if (cnt == 16'd0) begin
                    state_nx = GAP;
                    cnt_nx   = GAP_LD;
                end else begin
                    cnt_nx = cnt - 16'd1;
                end
            end
            GAP: begin
                if (cnt == 16'd0) begin
                    if (want) begin
                        start    = 1'b1;
                        state_nx = HIGH;
                        cnt_nx   = HOLD_LD;
                    end else begin
                        state_nx = IDLE;
                        cnt_nx   = 16'd0;
                    end
                end else begin
                    cnt_nx = cnt - 16'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 16'd0;
            end
        endcase
    end

    // A queued start consumes one entry; a coincident din replaces it.
    // A start with an empty queue absorbs the coincident din itself.
    always_comb begin
        pend_nx = pending;
        ovf_nx  = overflow;
        if (start) begin
            if (pending != 8'd0 && !din)
                pend_nx = pending - 8'd1;
        end else if (din) begin
            if (pending < PMAX)
                pend_nx = pending + 8'd1;
            else
                ovf_nx = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 16'd0;
            pending  <= 8'd0;
            overflow <= 1'b0;
            dout     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            pending  <= pend_nx;
            overflow <= ovf_nx;
            dout     <= (state_nx == HIGH);
            busy     <= (state_nx != IDLE);
        end
    end

endmodule

// File: tb/tb_pulse_stretch.sv
// Bench for pulse_stretch: directed scenarios plus random din, compared each
// cycle against a timeline model (start time of last high period + queue count).
module tb_pulse_stretch;

    localparam int H  = 4;
    localparam int G  = 2;
    localparam int PM = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b0;
    logic       dout, busy, overflow;
    logic [7:0] pending;

    int checks = 0;
    int errors = 0;

    // Reference model: the high period started at cycle st covers st..st+H-1,
    // the busy window st..st+H+G-1; a new start may land at st+H+G or later.
    int t;
    int st;
    int m_pend;
    bit m_ovf;
    int rises;
    bit prev_dout;

    pulse_stretch #(.HOLD_CYC(H), .GAP_CYC(G), .PEND_MAX(PM)) dut (
        .clk(clk), .rst(rst), .din(din),
        .dout(dout), .busy(busy), .pending(pending), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        t      = 0;
        st     = -1000;
        m_pend = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_edge(input bit d);
        bit ready;
        ready = (t + 1 >= st + H + G);
        if (ready && (d || m_pend > 0)) begin
            st = t + 1;
            if (m_pend > 0 && !d) m_pend = m_pend - 1;
        end else if (d) begin
            if (m_pend < PM) m_pend = m_pend + 1;
            else m_ovf = 1'b1;
        end
        t = t + 1;
    endtask

    task automatic check(input string tag);
        bit e_dout, e_busy;
        e_dout = (t >= st) && (t < st + H);
        e_busy = (t >= st) && (t < st + H + G);
        checks++;
        assert (dout === e_dout) else begin
            errors++;
            $error("FAIL %s dout t=%0d got %b exp %b", tag, t, dout, e_dout);
        end
        checks++;
        assert (busy === e_busy) else begin
            errors++;
            $error("FAIL %s busy t=%0d got %b exp %b", tag, t, busy, e_busy);
        end
        checks++;
        assert (pending === 8'(m_pend)) else begin
            errors++;
            $error("FAIL %s pending t=%0d got %0d exp %0d", tag, t, pending, m_pend);
        end
        checks++;
        assert (overflow === m_ovf) else begin
            errors++;
            $error("FAIL %s overflow t=%0d got %b exp %b", tag, t, overflow, m_ovf);
        end
        if (dout === 1'b1 && !prev_dout) rises++;
        prev_dout = (dout === 1'b1);
    endtask

    // din is driven at the negedge; the posedge samples it; outputs are checked
    // at the following negedge.
    task automatic cyc(input bit d, input string tag);
        din = d;
        @(posedge clk);
        model_edge(d);
        @(negedge clk);
        check(tag);
    endtask

    task automatic idle_n(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(1'b0, tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        prev_dout = 1'b0;
    endtask

    task automatic async_reset_check(input string tag);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        assert (dout === 1'b0 && busy === 1'b0 && pending === 8'd0 && overflow === 1'b0) else begin
            errors++;
            $error("FAIL %s got dout=%b busy=%b pend=%0d ovf=%b exp all 0",
                   tag, dout, busy, pending, overflow);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        prev_dout = 1'b0;
        check({tag, "_after"});
    endtask

    initial begin
        model_reset();
        prev_dout = 1'b0;
        rises = 0;
        @(negedge clk);
        check("reset");
        @(negedge clk);
        rst = 1'b0;

        // single pulse
        cyc(1'b1, "single");
        idle_n(8, "single");

        // burst of three
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, "burst");
        idle_n(20, "burst");

        // saturation: start, then five requests while high
        do_reset();
        rises = 0;
        cyc(1'b1, "sat");
        for (int i = 0; i < 5; i++) cyc(1'b1, "sat");
        idle_n(30, "sat");
        checks++;
        assert (rises == 4) else begin
            errors++;
            $error("FAIL sat_periods got %0d exp %0d", rises, 4);
        end

        // back-to-back: din on the last gap cycle with an empty queue
        do_reset();
        cyc(1'b1, "b2b");
        idle_n(H + G - 1, "b2b");
        cyc(1'b1, "b2b");
        idle_n(10, "b2b");

        // async reset mid-high with pending=2 and overflow set
        do_reset();
        for (int i = 0; i < 6; i++) cyc(1'b1, "ar_fill");
        cyc(1'b0, "ar_fill");
        cyc(1'b0, "ar_fill");
        async_reset_check("async_rst");
        cyc(1'b1, "ar_post");
        idle_n(8, "ar_post");

        // random traffic with varying density and occasional resets
        do_reset();
        for (int seg = 0; seg < 8; seg++) begin
            int dens;
            dens = $urandom_range(5, 80);
            for (int i = 0; i < 60; i++)
                cyc(($urandom_range(0, 99) < dens), "rand");
            if ($urandom_range(0, 2) == 0) async_reset_check("rand_rst");
        end
        idle_n(40, "drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pulse_stretch.md
PULSE_STRETCH -- requirements
Module: pulse_stretch

Interface
REQ-001 The module SHALL have parameter HOLD_CYC, default 4, number of cycles dout is held high per request (legal range 1..65535).
REQ-002 The module SHALL have parameter GAP_CYC, default 2, minimum number of low cycles between consecutive high periods (legal range 1..65535).
REQ-003 The module SHALL have parameter PEND_MAX, default 7, maximum queued requests (legal range 1..255).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 din  input  1  request; each cycle sampled high counts as one request.
REQ-007 dout  output  1  stretched output level.
REQ-008 busy  output  1  high whenever the FSM is not in IDLE.
REQ-009 pending  output  8  count of queued requests not yet started.
REQ-010 overflow  output  1  sticky flag; a request was dropped because the queue was full.

Function
REQ-011 The module SHALL implement a three-state FSM: IDLE, HIGH, GAP.
REQ-012 All outputs SHALL be driven from registers, with no combinational path from din to any output.
REQ-013 In IDLE, a start condition SHALL occur when din=1 or pending>0; the FSM then enters HIGH on that edge.
REQ-014 A request sampled in IDLE with pending=0 SHALL produce dout=1 on the first cycle after the sampling edge (latency 1).
REQ-015 In HIGH, dout SHALL be 1 for exactly HOLD_CYC consecutive cycles, after which the FSM SHALL enter GAP.
REQ-016 In GAP, dout SHALL be 0 for exactly GAP_CYC consecutive cycles.
REQ-017 At the last GAP cycle, if din=1 or pending>0, the FSM SHALL enter HIGH directly without passing through IDLE; otherwise it SHALL enter IDLE.
REQ-018 The HIGH and GAP duration counter SHALL be 16 bits, SHALL reload on every state entry, and SHALL never wrap.
REQ-019 A start taken from the queue (pending>0) SHALL decrement pending by 1 on the same edge.
REQ-020 When a start occurs and pending>0, a coincident din SHALL be queued, leaving pending unchanged (decrement and increment on the same edge).
REQ-021 When a start occurs with pending=0, a coincident din SHALL be consumed by the start and SHALL NOT be queued.
REQ-022 A din sampled in HIGH or GAP without a start SHALL increment pending if pending<PEND_MAX.
REQ-023 A din that would take pending above PEND_MAX SHALL be dropped and SHALL set overflow to 1.
REQ-024 overflow SHALL remain 1 until reset.
REQ-025 pending SHALL never exceed PEND_MAX and SHALL never underflow below 0.
REQ-026 busy SHALL be 1 in HIGH and GAP and 0 in IDLE.
REQ-027 When held high continuously, din SHALL be treated as one request per cycle.

Reset
REQ-028 While rst=1, the module SHALL hold state IDLE, dout=0, busy=0, pending=0, overflow=0, and counter=0, asynchronously to clk.
REQ-029 A reset asserted mid-HIGH or mid-GAP SHALL force dout=0 immediately and SHALL discard all queued requests.
REQ-030 After rst deasserts, the first din sampled high SHALL follow REQ-014.

Verification
Bench parameters: HOLD_CYC=4, GAP_CYC=2, PEND_MAX=3.
REQ-031 Single pulse: din=1 for 1 cycle from idle -> dout=1 cycles 1..4, then 0; busy=1 cycles 1..6; pending stays 0.
REQ-032 Burst: din=1 for 3 consecutive cycles from idle -> three 4-cycle highs separated by 2-cycle lows; pending peaks at 2 and returns to 0; overflow=0.
REQ-033 Saturation: one start pulse, then 5 pulses during HIGH -> pending saturates at 3, overflow=1; exactly 4 high periods total; overflow stays 1 afterwards.
REQ-034 Back-to-back: din=1 coincident with the last GAP cycle, pending=0 -> next HIGH begins on the following cycle, busy never drops, pending stays 0.
REQ-035 Async reset: rst pulsed mid-HIGH with pending=2 and overflow=1 -> dout, busy, pending, and overflow all read 0 before the next clk edge; a subsequent din yields a normal 4-cycle high.
